la_cmd_ctrl: RTL and testbench
==============================

LA_CMD_CTRL -- requirements
Module: la_cmd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, capture-memory address width; DEPTH = 2**ADDR_W bytes.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 rx_data_fresh  in  1  one-cycle strobe; rx_data holds a new received byte.
REQ-006 rx_data  in  8  received command or argument byte; sampled only when rx_data_fresh=1.
REQ-007 tx_busy  in  1  UART transmitter busy.
REQ-008 capture_done  in  1  one-cycle pulse from the capture engine; memory is full.
REQ-009 mem_rd_data  in  8  capture-memory read data; valid 1 cycle after mem_rd_en.
REQ-010 soft_rst  out  1  one-cycle system soft-reset pulse.
REQ-011 arm  out  1  level; capture engine armed.
REQ-012 trig_mask  out  8  trigger mask register.
REQ-013 trig_value  out  8  trigger compare-value register.
REQ-014 mem_rd_en  out  1  capture-memory read strobe.
REQ-015 mem_rd_addr  out  ADDR_W  capture-memory read address.
REQ-016 tx_start  out  1  one-cycle pulse; launch transmission of tx_data.
REQ-017 tx_data  out  8  byte to transmit; valid while tx_start=1.

Function
REQ-018 Command opcodes: 0xFF RESET, 0x01 ARM, 0x02 SET_MASK (+1 arg), 0x03 SET_VALUE (+1 arg), 0x04 DUMP, 0x05 STATUS; any other opcode ignored, state unchanged.
REQ-019 States: IDLE, GET_ARG, ARMED, DUMP_RD, DUMP_TX, DUMP_WAIT, STAT_TX, STAT_WAIT.
REQ-020 RESET (0xFF) in any state except GET_ARG: soft_rst=1 next cycle for exactly 1 cycle; state->IDLE; all registers to reset values; any dump or transmission in progress is aborted.
REQ-021 In GET_ARG, the next byte (including 0xFF) is the argument: it is written to trig_mask (SET_MASK) or trig_value (SET_VALUE); state->IDLE; register updates 1 cycle after the strobe.
REQ-022 ARM in IDLE: arm=1 from the next cycle; done_flag cleared; state->ARMED.
REQ-023 ARMED: capture_done=1 -> arm=0 next cycle, done_flag=1, state->IDLE; non-0xFF bytes are ignored.
REQ-024 STATUS in IDLE: state->STAT_TX; send byte {6'b0, done_flag, arm}.
REQ-025 DUMP in IDLE: mem_rd_addr=0; DUMP_RD asserts mem_rd_en for 1 cycle; DUMP_TX captures mem_rd_data and waits for tx_busy=0; DUMP_WAIT follows.
REQ-026 tx handshake: tx_start only while tx_busy=0; tx_data stable in the tx_start cycle; tx_busy is ignored for the 1 cycle after tx_start, then the block waits for tx_busy=0 before the next send.
REQ-027 DUMP_WAIT, tx idle: if mem_rd_addr=DEPTH-1 -> IDLE, address wraps to 0; else address+1 -> DUMP_RD; exactly DEPTH bytes sent, ascending order.
REQ-028 During dump/status, non-0xFF bytes are ignored; DUMP, STATUS or SET_* outside IDLE are ignored.
REQ-029 capture_done outside ARMED is ignored.
REQ-030 rx_data_fresh and capture_done in the same cycle in ARMED: RESET wins if byte=0xFF; otherwise capture_done is processed.
REQ-031 At most one tx_start per transmitted byte; no tx_start while tx_busy=1.

Reset
REQ-032 rst_n=0 asynchronously forces: state=IDLE, soft_rst=0, arm=0, done_flag=0, trig_mask=0x00, trig_value=0x00, mem_rd_en=0, mem_rd_addr=0, tx_start=0, tx_data=0x00.
REQ-033 Release of rst_n mid-transmission: no stale tx_start is issued; the block resumes in IDLE.

Verification
REQ-034 Bytes 0x02,0xA5 then 0x03,0xFF -> trig_mask=0xA5, trig_value=0xFF, soft_rst never asserted.
REQ-035 0x01 then capture_done pulse; then 0x05 -> arm high between the two, then low; one tx byte 0x02.
REQ-036 ADDR_W=3, memory = addr*3, 0x04 with tx_busy high 5 cycles after each start -> 8 bytes 0x00,0x03,...,0x15 in order, then IDLE.
REQ-037 0xFF during dump after 3 bytes -> soft_rst 1-cycle pulse, no further tx_start, mem_rd_addr=0, trig regs 0.
REQ-038 0x07, 0x04 while ARMED, and capture_done in IDLE -> no output or state change.
REQ-039 rst_n pulsed low mid-STATUS send -> all outputs at reset values immediately; a following 0x05 sends 0x00.

Source files
------------

// File: rtl/la_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// la_cmd_ctrl -- logic-analyser command controller
//
// Decodes single-byte commands from a UART receiver and drives the capture
// engine, the trigger registers, the capture-memory read port and the UART
// transmitter.
//
//   Opcode  Command     Action (only from IDLE unless noted)
//   0xFF    RESET       any state except GET_ARG: soft_rst pulse, full reset
//   0x01    ARM         arm=1, clear done_flag, wait for capture_done
//   0x02    SET_MASK    next byte -> trig_mask
//   0x03    SET_VALUE   next byte -> trig_value
//   0x04    DUMP        stream all DEPTH memory bytes, ascending address
//   0x05    STATUS      send {6'b0, done_flag, arm}
//   other               ignored
//
// Parameters
//   ADDR_W        capture-memory address width, DEPTH = 2**ADDR_W bytes
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx_data_fresh one-cycle strobe, rx_data holds a new byte
//   rx_data       received command / argument byte
//   tx_busy       UART transmitter busy
//   capture_done  one-cycle pulse, capture memory is full
//   mem_rd_data   capture-memory read data, valid 1 cycle after mem_rd_en
//   soft_rst      one-cycle system soft-reset pulse
//   arm           capture engine armed (level)
//   trig_mask     trigger mask register
//   trig_value    trigger compare-value register
//   mem_rd_en     capture-memory read strobe
//   mem_rd_addr   capture-memory read address
//   tx_start      one-cycle pulse, launch transmission of tx_data
//   tx_data       byte to transmit, valid while tx_start=1
// -----------------------------------------------------------------------------
module la_cmd_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_data_fresh,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  input  logic              capture_done,
  input  logic [7:0]        mem_rd_data,
  output logic              soft_rst,
  output logic              arm,
  output logic [7:0]        trig_mask,
  output logic [7:0]        trig_value,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              tx_start,
  output logic [7:0]        tx_data
);

  localparam logic [7:0] OP_RESET     = 8'hFF;
  localparam logic [7:0] OP_ARM       = 8'h01;
  localparam logic [7:0] OP_SET_MASK  = 8'h02;
  localparam logic [7:0] OP_SET_VALUE = 8'h03;
  localparam logic [7:0] OP_DUMP      = 8'h04;
  localparam logic [7:0] OP_STATUS    = 8'h05;

  // Highest memory address (DEPTH-1): the last byte of a dump.
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ARG,
    S_ARMED,
    S_DUMP_RD,
    S_DUMP_TX,
    S_DUMP_WAIT,
    S_STAT_TX,
    S_STAT_WAIT
  } state_t;

  state_t            state, state_n;
  logic              done_flag, done_flag_n;
  logic              arg_is_mask, arg_is_mask_n;   // which register GET_ARG writes
  logic              rd_first, rd_first_n;         // first DUMP_TX cycle: mem_rd_data valid
  logic              soft_rst_n;
  logic              arm_n;
  logic [7:0]        trig_mask_n, trig_value_n;
  logic              mem_rd_en_n;
  logic [ADDR_W-1:0] mem_rd_addr_n;
  logic              tx_start_n;
  logic [7:0]        tx_data_n;

  logic reset_cmd;
  logic tx_idle;

  // A 0xFF is a RESET everywhere except where it is the argument byte.
  assign reset_cmd = rx_data_fresh && (rx_data == OP_RESET) && (state != S_GET_ARG);

  // tx_busy is not trusted in the cycle tx_start is high: the transmitter
  // has not yet had the chance to raise it.
  assign tx_idle = !tx_start && !tx_busy;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; without it a
    // path that skips an assignment would infer a latch.
    state_n       = state;
    done_flag_n   = done_flag;
    arg_is_mask_n = arg_is_mask;
    rd_first_n    = 1'b0;
    soft_rst_n    = 1'b0;
    arm_n         = arm;
    trig_mask_n   = trig_mask;
    trig_value_n  = trig_value;
    mem_rd_en_n   = 1'b0;
    mem_rd_addr_n = mem_rd_addr;
    tx_start_n    = 1'b0;
    tx_data_n     = tx_data;

    if (reset_cmd) begin
      // Abort everything in progress and return every register to reset.
      state_n       = S_IDLE;
      soft_rst_n    = 1'b1;
      done_flag_n   = 1'b0;
      arg_is_mask_n = 1'b0;
      arm_n         = 1'b0;
      trig_mask_n   = 8'h00;
      trig_value_n  = 8'h00;
      mem_rd_addr_n = '0;
      tx_data_n     = 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_data_fresh) begin
            unique case (rx_data)
              OP_ARM: begin
                arm_n       = 1'b1;
                done_flag_n = 1'b0;
                state_n     = S_ARMED;
              end
              OP_SET_MASK: begin
                arg_is_mask_n = 1'b1;
                state_n       = S_GET_ARG;
              end
              OP_SET_VALUE: begin
                arg_is_mask_n = 1'b0;
                state_n       = S_GET_ARG;
              end
              OP_DUMP: begin
                mem_rd_addr_n = '0;
                mem_rd_en_n   = 1'b1;
                state_n       = S_DUMP_RD;
              end
              OP_STATUS: state_n = S_STAT_TX;
              default: ;
            endcase
          end
        end

        S_GET_ARG: begin
          if (rx_data_fresh) begin
            if (arg_is_mask) trig_mask_n  = rx_data;
            else             trig_value_n = rx_data;
            state_n = S_IDLE;
          end
        end

        S_ARMED: begin
          // A non-RESET byte arriving together with capture_done does not
          // block the capture completion.
          if (capture_done) begin
            arm_n       = 1'b0;
            done_flag_n = 1'b1;
            state_n     = S_IDLE;
          end
        end

        // mem_rd_en is high during this cycle; data appears next cycle.
        S_DUMP_RD: begin
          rd_first_n = 1'b1;
          state_n    = S_DUMP_TX;
        end

        S_DUMP_TX: begin
          if (!tx_busy) begin
            tx_start_n = 1'b1;
            tx_data_n  = rd_first ? mem_rd_data : tx_data;
            state_n    = S_DUMP_WAIT;
          end else if (rd_first) begin
            // Transmitter still busy: hold the read byte until it frees up.
            tx_data_n = mem_rd_data;
          end
        end

        S_DUMP_WAIT: begin
          if (tx_idle) begin
            if (mem_rd_addr == LAST_ADDR) begin
              mem_rd_addr_n = '0;
              state_n       = S_IDLE;
            end else begin
              mem_rd_addr_n = mem_rd_addr + ADDR_W'(1);
              mem_rd_en_n   = 1'b1;
              state_n       = S_DUMP_RD;
            end
          end
        end

        S_STAT_TX: begin
          if (!tx_busy) begin
            tx_start_n = 1'b1;
            tx_data_n  = {6'b0, done_flag, arm};
            state_n    = S_STAT_WAIT;
          end
        end

        S_STAT_WAIT: begin
          if (tx_idle) state_n = S_IDLE;
        end

        default: state_n = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      done_flag   <= 1'b0;
      arg_is_mask <= 1'b0;
      rd_first    <= 1'b0;
      soft_rst    <= 1'b0;
      arm         <= 1'b0;
      trig_mask   <= 8'h00;
      trig_value  <= 8'h00;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state       <= state_n;
      done_flag   <= done_flag_n;
      arg_is_mask <= arg_is_mask_n;
      rd_first    <= rd_first_n;
      soft_rst    <= soft_rst_n;
      arm         <= arm_n;
      trig_mask   <= trig_mask_n;
      trig_value  <= trig_value_n;
      mem_rd_en   <= mem_rd_en_n;
      mem_rd_addr <= mem_rd_addr_n;
      tx_start    <= tx_start_n;
      tx_data     <= tx_data_n;
    end
  end

endmodule

// File: tb/tb_la_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_la_cmd_ctrl -- self-checking bench for la_cmd_ctrl (ADDR_W=3, DEPTH=8)
//
// A command-level model (mode, register values, queue of bytes that must be
// transmitted) is compared against the DUT on every falling edge. A UART
// stand-in raises tx_busy for busy_len cycles after each tx_start; a memory
// stand-in returns mem_img[addr] one cycle after mem_rd_en. Directed
// scenarios with literal expectations run first, then randomized commands.
// -----------------------------------------------------------------------------
module tb_la_cmd_ctrl;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_data_fresh = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_busy;
  logic              capture_done = 1'b0;
  logic [7:0]        mem_rd_data = 8'h00;
  logic              soft_rst;
  logic              arm;
  logic [7:0]        trig_mask;
  logic [7:0]        trig_value;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              tx_start;
  logic [7:0]        tx_data;

  la_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data_fresh (rx_data_fresh),
    .rx_data       (rx_data),
    .tx_busy       (tx_busy),
    .capture_done  (capture_done),
    .mem_rd_data   (mem_rd_data),
    .soft_rst      (soft_rst),
    .arm           (arm),
    .trig_mask     (trig_mask),
    .trig_value    (trig_value),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .tx_start      (tx_start),
    .tx_data       (tx_data)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Environment: UART transmitter and capture memory
  // ---------------------------------------------------------------------------
  int busy_cnt = 0;
  int busy_len = 3;
  assign tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start)           busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] mem_img [DEPTH];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_img[mem_rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (command level)
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_ARG, M_ARMED, M_XFER} mode_t;

  mode_t      m_mode     = M_IDLE;
  logic       m_arm      = 1'b0;
  logic       m_done     = 1'b0;
  logic [7:0] m_mask     = 8'h00;
  logic [7:0] m_value    = 8'h00;
  logic       m_soft     = 1'b0;
  logic       m_arg_mask = 1'b0;
  int         m_rd_idx   = 0;
  int         xfer_quiet = 0;
  logic [7:0] exp_q[$];   // bytes still owed to the transmitter
  logic [7:0] tx_log[$];  // every byte the DUT launched
  int         soft_cnt   = 0;

  task automatic model_clear();
    m_mode     = M_IDLE;
    m_arm      = 1'b0;
    m_done     = 1'b0;
    m_mask     = 8'h00;
    m_value    = 8'h00;
    m_arg_mask = 1'b0;
    xfer_quiet = 0;
    exp_q.delete();
  endtask

  // Compare, then fold in the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_clear();
      m_soft = 1'b0;
    end

    check("soft_rst", soft_rst, m_soft);
    check("arm", arm, m_arm);
    check("trig_mask", trig_mask, m_mask);
    check("trig_value", trig_value, m_value);
    if (m_mode != M_XFER) begin
      check("mem_rd_en outside transfer", mem_rd_en, 0);
      check("mem_rd_addr outside transfer", mem_rd_addr, 0);
    end
    if (mem_rd_en) begin
      check("mem_rd_addr sequence", mem_rd_addr, m_rd_idx);
      m_rd_idx++;
    end
    if (soft_rst) soft_cnt++;
    if (tx_start) begin
      check("tx_start while busy", tx_busy, 0);
      tx_log.push_back(tx_data);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected tx_start: got data 0x%0h, required no transmission at %0t",
                 tx_data, $time);
      end else begin
        check("tx_data", tx_data, exp_q.pop_front());
      end
    end

    // A transfer is over once nothing is owed and the line has been quiet.
    if (m_mode == M_XFER) begin
      if (exp_q.size() == 0 && !tx_busy && !tx_start) xfer_quiet++;
      else xfer_quiet = 0;
      if (xfer_quiet >= 3) m_mode = M_IDLE;
    end

    m_soft = 1'b0;
    if (rst_n) begin
      if (rx_data_fresh && m_mode == M_ARG) begin
        if (m_arg_mask) m_mask = rx_data;
        else            m_value = rx_data;
        m_mode = M_IDLE;
      end else if (rx_data_fresh && rx_data == 8'hFF) begin
        model_clear();
        m_soft = 1'b1;
      end else if (m_mode == M_ARMED && capture_done) begin
        m_arm  = 1'b0;
        m_done = 1'b1;
        m_mode = M_IDLE;
      end else if (rx_data_fresh && m_mode == M_IDLE) begin
        case (rx_data)
          8'h01: begin m_arm = 1'b1; m_done = 1'b0; m_mode = M_ARMED; end
          8'h02: begin m_arg_mask = 1'b1; m_mode = M_ARG; end
          8'h03: begin m_arg_mask = 1'b0; m_mode = M_ARG; end
          8'h04: begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem_img[i]);
            m_rd_idx   = 0;
            xfer_quiet = 0;
            m_mode     = M_XFER;
          end
          8'h05: begin
            exp_q.push_back({6'b0, m_done, m_arm});
            xfer_quiet = 0;
            m_mode     = M_XFER;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] b, input logic cd = 1'b0);
    @(posedge clk); #2;
    rx_data_fresh = 1'b1;
    rx_data       = b;
    capture_done  = cd;
    @(posedge clk); #2;
    rx_data_fresh = 1'b0;
    capture_done  = 1'b0;
  endtask

  task automatic pulse_cd();
    @(posedge clk); #2;
    capture_done = 1'b1;
    @(posedge clk); #2;
    capture_done = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_xfer();
    for (int i = 0; i < 3000 && m_mode == M_XFER; i++) @(posedge clk);
    if (m_mode == M_XFER) begin
      n_tests++;
      n_fail++;
      $display("FAIL transfer timeout: still transferring, required completion at %0t", $time);
    end
    wait_cycles(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " soft_rst"}, soft_rst, 0);
    check({tag, " arm"}, arm, 0);
    check({tag, " trig_mask"}, trig_mask, 0);
    check({tag, " trig_value"}, trig_value, 0);
    check({tag, " mem_rd_en"}, mem_rd_en, 0);
    check({tag, " mem_rd_addr"}, mem_rd_addr, 0);
    check({tag, " tx_start"}, tx_start, 0);
    check({tag, " tx_data"}, tx_data, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int b0, s0, r;
    logic [7:0] byte_v;

    for (int i = 0; i < DEPTH; i++) mem_img[i] = 8'(i * 3);

    // Reset state
    wait_cycles(3); #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_cycles(2);

    // Mask / value setup; 0xFF as an argument is data, not RESET
    s0 = soft_cnt;
    send(8'h02); send(8'hA5); send(8'h03); send(8'hFF);
    wait_cycles(3);
    check("setup trig_mask", trig_mask, 8'hA5);
    check("setup trig_value", trig_value, 8'hFF);
    check("setup soft_rst count", soft_cnt - s0, 0);

    // Arm, capture, status
    send(8'h01);
    wait_cycles(2);
    check("armed arm", arm, 1);
    pulse_cd();
    wait_cycles(2);
    check("captured arm", arm, 0);
    b0 = tx_log.size();
    send(8'h05);
    wait_xfer();
    check("status byte count", tx_log.size() - b0, 1);
    check("status byte", tx_log[b0], 8'h02);

    // Full dump, transmitter busy 5 cycles per byte
    busy_len = 5;
    b0 = tx_log.size();
    send(8'h04);
    wait_xfer();
    check("dump byte count", tx_log.size() - b0, DEPTH);
    for (int i = 0; i < DEPTH; i++) check("dump byte", tx_log[b0 + i], 32'(8'(i * 3)));
    check("dump end addr", mem_rd_addr, 0);

    // RESET during a dump after three bytes
    send(8'h02); send(8'h3C); send(8'h03); send(8'h81);
    s0 = soft_cnt;
    b0 = tx_log.size();
    send(8'h04);
    for (int i = 0; i < 500 && tx_log.size() < b0 + 3; i++) @(negedge clk);
    send(8'hFF);
    wait_cycles(30);
    check("abort byte count", tx_log.size() - b0, 3);
    check("abort mem_rd_addr", mem_rd_addr, 0);
    check("abort trig_mask", trig_mask, 0);
    check("abort trig_value", trig_value, 0);
    check("abort soft_rst count", soft_cnt - s0, 1);

    // Ignored bytes while armed; capture_done in IDLE ignored
    busy_len = 3;
    b0 = tx_log.size();
    send(8'h01); send(8'h07); send(8'h04);
    wait_cycles(3);
    check("ignored arm", arm, 1);
    check("ignored tx count", tx_log.size() - b0, 0);
    pulse_cd();
    wait_cycles(2);
    pulse_cd();
    wait_cycles(2);
    send(8'h05);
    wait_xfer();
    check("ignored status byte", tx_log[b0], 8'h02);

    // Hardware reset in the middle of a STATUS transmission
    busy_len = 6;
    b0 = tx_log.size();
    send(8'h05);
    for (int i = 0; i < 100 && tx_log.size() == b0; i++) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    wait_cycles(2); #2;
    rst_n = 1'b1;
    b0 = tx_log.size();
    send(8'h05);
    wait_xfer();
    check("post-reset status count", tx_log.size() - b0, 1);
    check("post-reset status byte", tx_log[b0], 8'h00);

    // Randomized commands
    for (int it = 0; it < 300; it++) begin
      if (m_mode == M_XFER) begin
        r = $urandom_range(0, 9);
        if (r == 0)     send(8'hFF);
        else if (r < 5) send(8'($urandom_range(0, 254)));
        else            wait_cycles($urandom_range(1, 8));
      end else if (m_mode == M_ARG) begin
        send(8'($urandom));
      end else begin
        r = $urandom_range(0, 11);
        case (r)
          0: send(8'h01);
          1: send(8'h02);
          2: send(8'h03);
          3: begin
            for (int i = 0; i < DEPTH; i++) mem_img[i] = 8'($urandom);
            busy_len = $urandom_range(1, 6);
            send(8'h04);
          end
          4: begin
            busy_len = $urandom_range(1, 6);
            send(8'h05);
          end
          5: send(8'hFF);
          6, 7: pulse_cd();
          8: begin
            byte_v = 8'($urandom);
            send(byte_v, 1'($urandom));
          end
          9: send(8'($urandom_range(6, 254)));
          default: wait_cycles($urandom_range(1, 4));
        endcase
      end
    end
    wait_xfer();
    wait_cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
